// File: rtl/rns_pkg.sv
// Shared RNS constants and the reverse-converter FSM state type.
package rns_pkg;
  localparam int MOD_113         = 113;
  localparam int RW_113          = 7;
  localparam int INV_128_MOD_113 = 98;

  typedef enum logic [1:0] {IDLE, SUB, MUL, OUT} state_t;
endpackage

// File: rtl/mod_addsub_113.sv
// Combinational (a +/- b) mod MOD for operands already in 0..MOD-1; one correction step.
module mod_addsub_113 #(
  parameter int MOD = 113,
  parameter int W   = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);
  localparam logic [W-1:0] M = W'(MOD);

  logic [W-1:0] s;

  // W is one bit wider than the residue, so a+b and a+M-b cannot overflow
  always_comb begin
    s = a + b;
    if (sub) y = (a >= b) ? (a - b) : (a + M - b);
    else     y = (s >= M) ? (s - M) : s;
  end
endmodule

// File: rtl/rns_rev_113_128.sv
// Reverse converter {113,128} -> X via two-modulus CRT, bit-serial MSB-first multiply by INV.
// Optional input range check: define RNS_REV_RANGE_CHECK_EN.
module rns_rev_113_128 #(
  parameter int MOD = rns_pkg::MOD_113,
  parameter int RW  = rns_pkg::RW_113,
  parameter int INV = rns_pkg::INV_128_MOD_113
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RW-1:0]   in_ra,
  input  logic [RW-1:0]   in_rb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*RW-1:0] out_data,
  output logic            out_err
);
  import rns_pkg::*;

  localparam int            CW   = $clog2(RW);
  localparam logic [RW:0]   MODW = (RW+1)'(MOD);
  localparam logic [RW-1:0] MODR = RW'(MOD);
  localparam logic [RW-1:0] INVB = RW'(INV);

  state_t        state, state_nx;
  logic [RW-1:0] ra_q, rb_q, ra_in;
  logic [RW:0]   d_q, acc_q, bp, sub_y, dbl_y, add_b, add_y;
  logic [CW-1:0] cnt_q;
  logic          err_q, accept;

  assign accept = in_valid && (state == IDLE);

`ifdef RNS_REV_RANGE_CHECK_EN
  assign ra_in = in_ra;
  always_ff @(posedge clk)
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= (in_ra >= MODR);
`else
  // 2**RW-1 < 2*MOD, so one subtraction brings any RW-bit value into range
  assign ra_in = (in_ra >= MODR) ? (in_ra - MODR) : in_ra;
  assign err_q = 1'b0;
`endif

  assign bp    = ({1'b0, rb_q} >= MODW) ? ({1'b0, rb_q} - MODW) : {1'b0, rb_q};
  assign add_b = INVB[cnt_q] ? d_q : '0;

  mod_addsub_113 #(.MOD(MOD), .W(RW+1)) u_sub (
    .a({1'b0, ra_q}), .b(bp), .sub(1'b1), .y(sub_y));
  mod_addsub_113 #(.MOD(MOD), .W(RW+1)) u_dbl (
    .a(acc_q), .b(acc_q), .sub(1'b0), .y(dbl_y));
  mod_addsub_113 #(.MOD(MOD), .W(RW+1)) u_add (
    .a(dbl_y), .b(add_b), .sub(1'b0), .y(add_y));

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)        state_nx = SUB;
      SUB:                          state_nx = MUL;
      MUL:     if (cnt_q == '0)     state_nx = OUT;
      OUT:     if (out_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    out_err   = out_valid && err_q;
    out_data  = (out_valid && !err_q) ? {acc_q[RW-1:0], rb_q} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q  <= '0;
      rb_q  <= '0;
      d_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra_q <= ra_in;
          rb_q <= in_rb;
        end
        SUB: begin
          d_q   <= sub_y;
          acc_q <= '0;
          cnt_q <= CW'(RW-1);
        end
        MUL: begin
          acc_q <= add_y;
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rns_rev_113_128.sv
// Bench for rns_rev_113_128: CRT scoreboard by exhaustive search, directed cases, random sweep.
module tb_rns_rev_113_128;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [6:0]  in_ra, in_rb;
  logic [13:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit first_seen = 1'b0;

  typedef struct { int x; bit err; } exp_t;
  exp_t q[$];

  rns_rev_113_128 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ra(in_ra), .in_rb(in_rb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // X is the unique value in 0..14463 with the given residues
  function automatic int model_x(input int ra, input int rb);
    for (int x = 0; x < 113*128; x++)
      if ((x % 113) == (ra % 113) && (x % 128) == rb) return x;
    return -1;
  endfunction

  function automatic exp_t model(input int ra, input int rb);
    exp_t e;
`ifdef RNS_REV_RANGE_CHECK_EN
    e.err = (ra >= 113);
    e.x   = e.err ? 0 : model_x(ra, rb);
`else
    e.err = 1'b0;
    e.x   = model_x(ra, rb);
`endif
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) q.delete();
    else begin
      if (in_valid && in_ready) begin
        q.push_back(model(int'(in_ra), int'(in_rb)));
        acc_cyc    = cyc;
        first_seen = 1'b0;
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        chk("out_data", int'(out_data), q[0].x);
        chk("out_err", int'(out_err), int'(q[0].err));
        if (!first_seen) begin
          chk("latency_edges", cyc - acc_cyc, 8);
          first_seen = 1'b1;
        end
      end
    end
  end

  // Called just after a negedge; returns after the output handshake.
  task automatic convert(input int ra, input int rb, input bit stall,
                         output int d, output int e);
    int n;
    bit done;
    in_ra = 7'(ra); in_rb = 7'(rb); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    d = -1; e = -1; n = 0; done = 1'b0;
    while (!done) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        d = int'(out_data); e = int'(out_err);
        @(negedge clk);
        out_ready = 1'b0;
        done = 1'b1;
      end else if (n > 80) begin
        chk("out_valid_timeout", 0, 1);
        out_ready = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, e, x, n;
    bit bad;
    rst = 1'b1; in_valid = 1'b0; in_ra = '0; in_rb = '0; out_ready = 1'b0;

    chk("model_0",     model_x(0, 0),     0);
    chk("model_200",   model_x(87, 72),   200);
    chk("model_1000",  model_x(96, 104),  1000);
    chk("model_max",   model_x(112, 127), 14463);
    chk("model_ra7",   model_x(7, 5),     10629);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_err",   int'(out_err),   0);

    convert(0, 0, 0, d, e);     chk("x0_data", d, 0);  chk("x0_err", e, 0);
    convert(87, 72, 0, d, e);   chk("x200", d, 200);
    convert(96, 104, 0, d, e);  chk("x1000", d, 1000); chk("x1000_k", d / 128, 7);
    convert(112, 127, 0, d, e); chk("xmax", d, 14463);

    // held output under backpressure, competing input ignored
    in_ra = 7'd96; in_rb = 7'd104; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("stall_reach_out", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_ra = 7'd5; in_rb = 7'd5; in_valid = 1'b1;
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_hold_valid", int'(out_valid), 1);
      chk("stall_hold_data", int'(out_data), 1000);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_in_ready", int'(in_ready), 1);
    repeat (12) @(negedge clk);

    // reset during MUL cycle 3
    in_ra = 7'd50; in_rb = 7'd60; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    bad = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) bad = 1'b1; end
    chk("abort_no_output", int'(bad), 0);
    convert(1, 1, 0, d, e);     chk("after_abort", d, 1);

    convert(120, 5, 0, d, e);
`ifdef RNS_REV_RANGE_CHECK_EN
    chk("range_err", e, 1);     chk("range_data", d, 0);
`else
    chk("range_err", e, 0);     chk("range_data", d, 10629);
`endif

    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(0, 113*128-1);
      convert(x % 113, x % 128, 1, d, e);
      chk("sweep_x", d, x);
    end
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(113, 127);
      convert(x, $urandom_range(0, 127), 1, d, e);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
